fmul_arbiter: RTL and testbench
===============================

Name: fmul_arbiter

Overview:
- Shares one fmul unit between NUM_REQ requesters (e.g. integer-issue and vector-issue ports).
- Uses the same order/accepted/done handshake as the FPU units on both sides.
- Latches the winning operands and holds them stable to the unit until done, then routes the result and done pulse back to the winner.
- Sits between the issue logic and the single fmul instance.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- GRANT_W, $clog2(NUM_REQ), derived localparam; width of grant index.

Ports:
- clk  input  1  clock
- rstn  input  1  reset, synchronous, active-low
- req_order  input  NUM_REQ  per-requester order; held high with operands stable until accepted
- req_accepted  output  NUM_REQ  one-hot, 1-cycle pulse; order taken this cycle
- req_done  output  NUM_REQ  one-hot, 1-cycle pulse; result valid on req_rd this cycle
- req_rs1  input  NUM_REQ*32  packed operand 1; slice i belongs to requester i
- req_rs2  input  NUM_REQ*32  packed operand 2
- req_rd  output  32  result; qualified only by req_done
- fu_order  output  1  order to fmul
- fu_accepted  input  1  fmul accepted
- fu_done  input  1  fmul done
- fu_rs1  output  32  operand 1 to fmul
- fu_rs2  output  32  operand 2 to fmul
- fu_rd  input  32  fmul result
- busy  output  1  high in ISSUE or WAIT
- grant_id  output  GRANT_W  index of current or most recent winner

Behaviour:
- Reset values:
  - all outputs 0;
  - state IDLE;
  - operand regs 0;
  - last_grant = NUM_REQ-1, so requester 0 has first priority after reset.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_order bit is set, pick winner g by round-robin: first set bit searching upward from last_grant+1, wrapping at NUM_REQ-1 -> 0.
  - req_accepted[g]=1 combinationally this cycle.
  - On the clock edge, latch req_rs1/req_rs2 slice g into operand regs; grant_id<=g; last_grant<=g; next state ISSUE.
  - If no request, stay in IDLE; no outputs asserted.
- ISSUE:
  - fu_order=1; fu_rs1/fu_rs2 driven from operand regs.
  - fu_accepted=1 -> WAIT.
  - fu_accepted=0 -> stay; fu_order stays high, operands unchanged.
- WAIT:
  - fu_order=0; operands held stable, because fmul stage registers sample every cycle.
  - On fu_done:
    - req_done[grant_id]=1 in the same cycle;
    - req_rd=fu_rd, combinational pass-through;
    - next state IDLE.
- fu_rd passes straight to req_rd in all states; consumers must ignore it unless req_done is high.
- req_accepted is never asserted outside IDLE. A requester cannot be re-accepted while any operation is in flight (one operation in flight total).
- No new acceptance in the cycle fu_done is seen. Next grant is earliest the following cycle (IDLE).
- Latency, with the fmul's fixed done counter:
  - accept at cycle T -> fu_order/fu_accepted at T+1 -> req_done at T+4;
  - next accept no earlier than T+5.
- A requester dropping req_order before acceptance is legal; it is simply not granted.
- req_order bits of non-winners are ignored until IDLE.
- fu_done outside WAIT: ignored; no req_done is generated.
- Reset mid-operation (ISSUE or WAIT):
  - all state cleared next edge; in-flight result discarded; no req_done emitted;
  - fmul shares rstn and is cleared too.
- busy = (state != IDLE).

Optional Feature:
- Macro: FMUL_ARB_FIXED_PRIORITY_EN.
- Defined: winner is always the lowest-index requester with req_order set. last_grant is still updated for grant_id but is ignored for selection.
- Undefined: round-robin as described above (default).

Test Plan:
1. Single operation: req_order[0]=1, rs1=0x40000000 (2.0), rs2=0x40400000 (3.0) at T -> req_accepted[0] at T; fu_order at T+1; req_done[0] at T+4 with req_rd=0x40C00000; busy low at T+5.
2. Simultaneous requests after reset: req0 (0x3FC00000 x 0x40000000) and req1 (0xC0000000 x 0x40800000) both at T -> req0 accepted at T, done at T+4 with rd=0x40400000; req1 accepted at T+5, done at T+9 with rd=0xC1000000.
3. Round-robin fairness: both requesters hold order continuously for 4 operations -> grant_id sequence 0,1,0,1; every req_done goes to the matching requester only.
4. Unit stall: stub fu_accepted=0 for 3 cycles in ISSUE -> fu_order high for 4 cycles; fu_rs1/fu_rs2 constant; no req_done; then normal completion 3 cycles after acceptance.
5. Reset during WAIT: rstn=0 at T+2 of an operation -> all outputs 0 next cycle; no req_done ever for that operation; a new request afterwards completes normally with correct rd.
6. With FMUL_ARB_FIXED_PRIORITY_EN, both requesters asserting continuously -> requester 0 granted 4 times consecutively; req_accepted[1] never asserted.

Source files
------------

// File: rtl/fmul_arbiter.sv
// fmul_arbiter: shares a single fmul unit between NUM_REQ requesters.
// The winner's operands are latched and held stable to the unit until its
// done pulse, which is then routed back to the winner together with fu_rd.
// Build option: FMUL_ARB_FIXED_PRIORITY_EN selects lowest-index-wins
// arbitration instead of the default round-robin.
//
// Handshake (both sides): order is held high with operands stable until the
// cycle in which accepted is seen high; that cycle transfers the order. done
// is a single-cycle pulse and the result is only meaningful in that cycle.
module fmul_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int GRANT_W = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NUM_REQ-1:0]    req_order,
    output logic [NUM_REQ-1:0]    req_accepted,
    output logic [NUM_REQ-1:0]    req_done,
    input  logic [NUM_REQ*32-1:0] req_rs1,
    input  logic [NUM_REQ*32-1:0] req_rs2,
    output logic [31:0]           req_rd,
    output logic                  fu_order,
    input  logic                  fu_accepted,
    input  logic                  fu_done,
    output logic [31:0]           fu_rs1,
    output logic [31:0]           fu_rs2,
    input  logic [31:0]           fu_rd,
    output logic                  busy,
    output logic [GRANT_W-1:0]    grant_id,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [GRANT_W-1:0] last_grant;
    logic [31:0]        op1;
    logic [31:0]        op2;
    logic [GRANT_W-1:0] pick;
    logic               pick_valid;
    logic               do_accept;

    // Winner selection among the currently asserted orders.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
`ifdef FMUL_ARB_FIXED_PRIORITY_EN
        // Lowest index wins; last_grant plays no part in selection.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_order[k]) begin
                pick_valid = 1'b1;
                pick       = GRANT_W'(k);
            end
        end
`else
        // Round-robin: first set bit searching upward from last_grant+1, wrapping.
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!pick_valid && req_order[(int'(last_grant) + k) % NUM_REQ]) begin
                pick_valid = 1'b1;
                pick       = GRANT_W'((int'(last_grant) + k) % NUM_REQ);
            end
        end
`endif
    end

    // State register plus operand/grant capture on acceptance.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            op1        <= '0;
            op2        <= '0;
            grant_id   <= '0;
            last_grant <= GRANT_W'(NUM_REQ - 1);
        end else begin
            state <= state_nxt;
            if (do_accept) begin
                op1        <= req_rs1[int'(pick) * 32 +: 32];
                op2        <= req_rs2[int'(pick) * 32 +: 32];
                grant_id   <= pick;
                last_grant <= pick;
            end
        end
    end

    // Next-state and handshake outputs; one operation in flight at a time.
    always_comb begin
        state_nxt    = state;
        req_accepted = '0;
        req_done     = '0;
        fu_order     = 1'b0;
        do_accept    = 1'b0;
        case (state)
            IDLE: begin
                // Accept only outside reset so nothing appears taken that is not latched.
                if (pick_valid && rstn) begin
                    do_accept          = 1'b1;
                    req_accepted[pick] = 1'b1;
                    state_nxt          = ISSUE;
                end
            end
            ISSUE: begin
                fu_order = 1'b1;
                if (fu_accepted) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // fu_done in any other state is a stray pulse and is dropped.
                if (fu_done) begin
                    req_done[grant_id] = 1'b1;
                    state_nxt          = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands stay on the unit bus after issue: the fmul stage samples every cycle.
    assign fu_rs1    = op1;
    assign fu_rs2    = op2;
    assign req_rd    = fu_rd;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_fmul_arbiter.sv
// Directed bench for fmul_arbiter with a small fmul stub (fixed 3-cycle
// done counter, result from a table of hand-computed IEEE-754 products).
module tb_fmul_arbiter;

  localparam int NUM_REQ = 2;
  localparam int W       = 34;   // {requester index[1:0], result[31:0]}

  logic                  clk;
  logic                  rstn;
  logic [NUM_REQ-1:0]    req_order;
  logic [NUM_REQ-1:0]    req_accepted;
  logic [NUM_REQ-1:0]    req_done;
  logic [NUM_REQ*32-1:0] req_rs1;
  logic [NUM_REQ*32-1:0] req_rs2;
  logic [31:0]           req_rd;
  logic                  fu_order;
  logic                  fu_accepted;
  logic                  fu_done;
  logic [31:0]           fu_rs1;
  logic [31:0]           fu_rs2;
  logic [31:0]           fu_rd;
  logic                  busy;
  logic [0:0]            grant_id;
  logic [1:0]            dbg_state;

  int n_cmp;
  int n_err;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_ent;

  // fmul stub controls
  logic       stall_en;
  logic       fu_done_force;
  logic [1:0] fm_cnt;
  logic [31:0] fm_res;

  fmul_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_order    (req_order),
    .req_accepted (req_accepted),
    .req_done     (req_done),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .req_rd       (req_rd),
    .fu_order     (fu_order),
    .fu_accepted  (fu_accepted),
    .fu_done      (fu_done),
    .fu_rs1       (fu_rs1),
    .fu_rs2       (fu_rs2),
    .fu_rd        (fu_rd),
    .busy         (busy),
    .grant_id     (grant_id),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // hand-computed single-precision products used by the stub
  function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000; // 2.0*3.0
    if (a == 32'h3FC00000 && b == 32'h40000000) return 32'h40400000; // 1.5*2.0
    if (a == 32'hC0000000 && b == 32'h40800000) return 32'hC1000000; // -2.0*4.0
    if (a == 32'h40800000 && b == 32'h40800000) return 32'h41800000; // 4.0*4.0
    return 32'hDEADBEEF;
  endfunction

  // fmul stub: accepts unless stalled, done 3 cycles after acceptance
  assign fu_accepted = fu_order && !stall_en;
  assign fu_done     = (fm_cnt == 2'd1) || fu_done_force;
  assign fu_rd       = fm_res;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fm_cnt <= 2'd0;
      fm_res <= 32'd0;
    end else if (fu_order && fu_accepted) begin
      fm_cnt <= 2'd3;
      fm_res <= fmul_ref(fu_rs1, fu_rs2);
    end else if (fm_cnt != 2'd0) begin
      fm_cnt <= fm_cnt - 2'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_rs1[i*32 +: 32] = a;
    req_rs2[i*32 +: 32] = b;
  endtask

  task automatic do_reset();
    rstn          = 1'b0;
    req_order     = '0;
    stall_en      = 1'b0;
    fu_done_force = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  // scoreboard: every req_done must match the oldest expected completion
  always @(negedge clk) begin
    #2;
    if (req_done != '0) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_done", {30'd0, req_done}, 32'd0);
      end else begin
        exp_ent = exp_q.pop_front();
        check("sb_done_port", {30'd0, req_done}, 32'd1 << exp_ent[33:32]);
        check("sb_done_rd", req_rd, exp_ent[31:0]);
      end
    end
    if (req_accepted != '0) check("sb_acc_while_busy", {31'd0, busy}, 32'd0);
  end

  logic [1:0] rr_exp [4];

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    req_rs1 = '0;
    req_rs2 = '0;
    do_reset();

    // reset state
    #1;
    check("rst_acc", {30'd0, req_accepted}, 32'd0);
    check("rst_done", {30'd0, req_done}, 32'd0);
    check("rst_fu_order", {31'd0, fu_order}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_grant", {31'd0, grant_id}, 32'd0);
    check("rst_fu_rs1", fu_rs1, 32'd0);
    check("rst_rd", req_rd, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    // 1: single operation, 2.0 x 3.0
    @(negedge clk); req_order = 2'b01; set_ops(0, 32'h40000000, 32'h40400000); #1;
    check("t1_acc", {30'd0, req_accepted}, 32'd1);
    exp_q.push_back({2'd0, 32'h40C00000});
    @(negedge clk); req_order = 2'b00; #1;                 // T+1
    check("t1_fu_order", {31'd0, fu_order}, 32'd1);
    check("t1_fu_rs1", fu_rs1, 32'h40000000);
    check("t1_fu_rs2", fu_rs2, 32'h40400000);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_state_issue", {30'd0, dbg_state}, 32'd1);
    @(negedge clk); req_order = 2'b10; #1;                 // T+2: req1 ignored while busy
    check("t1_fu_order_low", {31'd0, fu_order}, 32'd0);
    check("t1_no_acc_busy", {30'd0, req_accepted}, 32'd0);
    check("t1_rs1_held", fu_rs1, 32'h40000000);
    check("t1_state_wait", {30'd0, dbg_state}, 32'd2);
    @(negedge clk); req_order = 2'b00; #1;                 // T+3: req1 withdraws
    check("t1_no_done_early", {30'd0, req_done}, 32'd0);
    @(negedge clk); #1;                                    // T+4
    check("t1_done", {30'd0, req_done}, 32'd1);
    check("t1_rd", req_rd, 32'h40C00000);
    @(negedge clk); #1;                                    // T+5
    check("t1_idle", {31'd0, busy}, 32'd0);
    check("t1_withdrawn_not_acc", {30'd0, req_accepted}, 32'd0);

    // 2: simultaneous requests after reset
    do_reset();
    @(negedge clk); req_order = 2'b11;
    set_ops(0, 32'h3FC00000, 32'h40000000);
    set_ops(1, 32'hC0000000, 32'h40800000); #1;
    check("t2_acc0", {30'd0, req_accepted}, 32'd1);
    exp_q.push_back({2'd0, 32'h40400000});
    @(negedge clk); req_order = 2'b10; #1;                 // T+1
    check("t2_no_acc1_busy", {30'd0, req_accepted}, 32'd0);
    repeat (3) @(negedge clk); #1;                         // T+4
    check("t2_done0", {30'd0, req_done}, 32'd1);
    check("t2_rd0", req_rd, 32'h40400000);
    @(negedge clk); #1;                                    // T+5
    check("t2_acc1", {30'd0, req_accepted}, 32'd2);
    exp_q.push_back({2'd1, 32'hC1000000});
    @(negedge clk); req_order = 2'b00; #1;                 // T+6
    check("t2_grant1", {31'd0, grant_id}, 32'd1);
    check("t2_fu_rs1", fu_rs1, 32'hC0000000);
    check("t2_fu_rs2", fu_rs2, 32'h40800000);
    repeat (3) @(negedge clk); #1;                         // T+9
    check("t2_done1", {30'd0, req_done}, 32'd2);
    check("t2_rd1", req_rd, 32'hC1000000);

    // 3: both requesters hold order for 4 operations
`ifdef FMUL_ARB_FIXED_PRIORITY_EN
    rr_exp = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
    rr_exp = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
    @(negedge clk); req_order = 2'b11;
    set_ops(0, 32'h40000000, 32'h40400000);
    set_ops(1, 32'h40800000, 32'h40800000);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      check("t3_acc", {30'd0, req_accepted}, 32'd1 << rr_exp[k]);
      exp_q.push_back({rr_exp[k], (rr_exp[k] == 2'd0) ? 32'h40C00000 : 32'h41800000});
      @(negedge clk); #1;
      check("t3_grant", {31'd0, grant_id}, {30'd0, rr_exp[k]});
      repeat (3) @(negedge clk); #1;
      check("t3_done", {30'd0, req_done}, 32'd1 << rr_exp[k]);
    end
    @(negedge clk); req_order = 2'b00; #1;
    check("t3_idle", {31'd0, busy}, 32'd0);

    // stray fu_done in IDLE is ignored
    @(negedge clk); fu_done_force = 1'b1; #1;
    check("t4_stray_idle_done", {30'd0, req_done}, 32'd0);
    @(negedge clk); fu_done_force = 1'b0; #1;
    check("t4_stray_idle_busy", {31'd0, busy}, 32'd0);

    // 4: unit stalls acceptance for 3 cycles
    @(negedge clk); req_order = 2'b01; stall_en = 1'b1;
    set_ops(0, 32'h40000000, 32'h40400000); #1;
    check("t4_acc", {30'd0, req_accepted}, 32'd1);
    exp_q.push_back({2'd0, 32'h40C00000});
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); req_order = 2'b00;
      fu_done_force = (c == 2);
      stall_en      = (c < 4);
      #1;
      check("t4_stall_order", {31'd0, fu_order}, 32'd1);
      check("t4_stall_rs1", fu_rs1, 32'h40000000);
      check("t4_stall_rs2", fu_rs2, 32'h40400000);
      check("t4_stall_no_done", {30'd0, req_done}, 32'd0);
    end
    @(negedge clk); fu_done_force = 1'b0; #1;              // acceptance + 1
    check("t4_order_drop", {31'd0, fu_order}, 32'd0);
    @(negedge clk); #1;                                    // acceptance + 2
    check("t4_no_done_yet", {30'd0, req_done}, 32'd0);
    @(negedge clk); #1;                                    // acceptance + 3
    check("t4_done", {30'd0, req_done}, 32'd1);
    check("t4_rd", req_rd, 32'h40C00000);

    // 5: reset while the operation is in WAIT
    @(negedge clk); req_order = 2'b10;
    set_ops(1, 32'h40800000, 32'h40800000); #1;
    check("t5_acc", {30'd0, req_accepted}, 32'd2);
    @(negedge clk); req_order = 2'b00;                     // T+1
    @(negedge clk); rstn = 1'b0; #1;                       // T+2
    check("t5_busy_before_rst", {31'd0, busy}, 32'd1);
    @(negedge clk); #1;                                    // T+3
    check("t5_rst_acc", {30'd0, req_accepted}, 32'd0);
    check("t5_rst_done", {30'd0, req_done}, 32'd0);
    check("t5_rst_order", {31'd0, fu_order}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_grant", {31'd0, grant_id}, 32'd0);
    check("t5_rst_rs1", fu_rs1, 32'd0);
    check("t5_rst_rs2", fu_rs2, 32'd0);
    check("t5_rst_rd", req_rd, 32'd0);
    @(negedge clk); rstn = 1'b1;
    repeat (4) @(negedge clk);                             // scoreboard flags any late done
    #1;
    check("t5_quiet_after_rst", {31'd0, busy}, 32'd0);
    @(negedge clk); req_order = 2'b10; #1;
    check("t5_acc_after", {30'd0, req_accepted}, 32'd2);
    exp_q.push_back({2'd1, 32'h41800000});
    @(negedge clk); req_order = 2'b00;
    repeat (3) @(negedge clk); #1;
    check("t5_done_after", {30'd0, req_done}, 32'd2);
    check("t5_rd_after", req_rd, 32'h41800000);

    repeat (3) @(negedge clk);
    #3;
    check("sb_queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
